// File: rtl/instr_encoder.sv
// Instruction encoder: packs decoded fields back into 32-bit instructions and
// expands the LI pseudo-op into ADDI, LUI or a LUI+ADDI pair.
`timescale 1ns/1ps

module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_SB = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_LI = 3'd5;

    localparam logic [6:0]  OP_OPIMM = 7'b0010011;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, HOLD, LI2} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_outInstr;
    logic        r_outErr;
    logic [31:0] r_pendAddi;
    logic [7:0]  r_errCount;

    logic        w_accept;
    logic        w_immFits;
    logic [11:0] w_lo;
    logic [19:0] w_hi;
    logic [31:0] w_word0;
    logic [31:0] w_word1;
    logic        w_twoWord;
    logic        w_err;

    assign out_valid = (r_state != IDLE);
    assign in_ready  = !reset && (r_state != LI2) && (!out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    // A value fits a signed 12-bit field when bits 31..11 are all copies of the sign.
    assign w_immFits = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign w_lo      = in_imm[11:0];
    // ADDI sign-extends lo, so the upper part must absorb the borrow when lo is negative.
    assign w_hi      = in_imm[31:12] + {19'b0, in_imm[11]};

    always_comb begin
        w_word0   = NOP;
        w_word1   = '0;
        w_twoWord = 1'b0;
        w_err     = 1'b0;
        case (in_fmt)
            FMT_R:  w_word0 = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: begin
                w_word0 = {w_lo, in_rs1, in_funct3, in_rd, in_opcode};
                w_err   = !w_immFits;
            end
            FMT_S: begin
                w_word0 = {w_lo[11:5], in_rs2, in_rs1, in_funct3, w_lo[4:0], in_opcode};
                w_err   = !w_immFits;
            end
            FMT_SB: begin
                w_word0 = {w_lo[11], w_lo[9:4], in_rs2, in_rs1, in_funct3,
                           w_lo[3:0], w_lo[10], in_opcode};
                w_err   = !w_immFits;
            end
            FMT_U: begin
                w_word0 = {in_imm[31:12], in_rd, in_opcode};
                w_err   = (in_imm[11:0] != 12'd0);
            end
            FMT_LI: begin
                if (w_immFits) begin
                    w_word0 = {w_lo, 5'd0, 3'b000, in_rd, OP_OPIMM};
                end else if (w_lo == 12'd0) begin
                    w_word0 = {w_hi, in_rd, OP_LUI};
                end else begin
                    w_word0   = {w_hi, in_rd, OP_LUI};
                    w_word1   = {w_lo, in_rd, 3'b000, in_rd, OP_OPIMM};
                    w_twoWord = 1'b1;
                end
            end
            default: begin
                w_word0 = NOP;
                w_err   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_nextState = w_twoWord ? LI2 : HOLD;
            end
            HOLD: begin
                if (w_accept)       w_nextState = w_twoWord ? LI2 : HOLD;
                else if (out_ready) w_nextState = IDLE;
            end
            LI2: begin
                if (out_ready) w_nextState = HOLD;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Output word only changes on an accept or when the held LUI drains into its ADDI.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outInstr <= '0;
            r_outErr   <= 1'b0;
            r_pendAddi <= '0;
            r_errCount <= '0;
        end else if (w_accept) begin
            r_outInstr <= w_word0;
            r_outErr   <= w_err;
            r_pendAddi <= w_word1;
            if (w_err && (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end else if ((r_state == LI2) && out_ready) begin
            r_outInstr <= r_pendAddi;
            r_outErr   <= 1'b0;
        end
    end

    assign out_instr = r_outInstr;
    assign out_err   = r_outErr;
    assign err_count = r_errCount;

endmodule
